conv_ram_arbiter: RTL and testbench

// - Shares the single-port 4096x8 image RAM between two requesters: port A (convolution window

---
 rtl/conv_ram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_conv_ram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ram_arbiter.sv
// conv_ram_arbiter: shares one single-port image RAM between port A (convolution window
// fetch, read-only) and port B (host load / result write-back). Round-robin arbitration
// with an optional burst lock bounded by MAX_BURST when the other port is waiting.
// RAM command signals are registered; read data returns two cycles after the grant
// to the port that issued the read.
// Build option: define CONV_RAM_ARB_STATS_EN to add saturating counters of accepted
// beats per port (stat_a_beats, stat_b_beats) and forced burst exits (stat_force).
module conv_ram_arbiter #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_w_en,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
`ifdef CONV_RAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_a_beats,
  output logic [15:0]   stat_b_beats,
  output logic [7:0]    stat_force
`endif
);

  localparam int unsigned CW = 8;   // burst counter width, covers MAX_BURST up to 255
  localparam int unsigned SW = 16;  // beat statistics width
  localparam int unsigned FW = 8;   // forced-exit statistics width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;          // 0: next tie goes to A, 1: next tie goes to B
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc_c;
  logic          at_limit_c;
  logic          a_gnt_c, b_gnt_c;
  logic          force_c;

  // RAM command registers
  logic          ram_w_en_q, ram_r_en_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;

  // Read-source tags: cmd stage travels with the RAM command, rvalid stage with the data
  logic          rd_a_q, rd_b_q;
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_hold_q, b_hold_q;
  logic          busy_q;

  // Grant selection and next ownership / round-robin / burst state
  always_comb begin
    a_gnt_c    = 1'b0;
    b_gnt_c    = 1'b0;
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    force_c    = 1'b0;
    cnt_inc_c  = {1'b0, cnt_q} + (CW+1)'(1);
    at_limit_c = (cnt_inc_c >= (CW+1)'(MAX_BURST));

    unique case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          a_gnt_c = ~rr_q;
          b_gnt_c = rr_q;
        end else begin
          a_gnt_c = a_req;
          b_gnt_c = b_req;
        end
      end
      OWN_A:   a_gnt_c = a_req;
      OWN_B:   b_gnt_c = b_req;
      default: state_d = IDLE;
    endcase

    // Nothing is accepted while reset is held
    if (!rst_n) begin
      a_gnt_c = 1'b0;
      b_gnt_c = 1'b0;
    end

    if (a_gnt_c) begin
      // Pointer always moves away from the port just served
      rr_d = 1'b1;
      if (a_lock && !(at_limit_c && b_req)) begin
        state_d = OWN_A;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_inc_c[CW-1:0];
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        force_c = a_lock;
      end
    end else if (b_gnt_c) begin
      rr_d = 1'b0;
      if (b_lock && !(at_limit_c && a_req)) begin
        state_d = OWN_B;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_inc_c[CW-1:0];
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        force_c = b_lock;
      end
    end else if (state_q == OWN_A && !a_req) begin
      // Owner released the lock without a further beat
      state_d = IDLE;
      cnt_d   = '0;
      rr_d    = 1'b1;
    end else if (state_q == OWN_B && !b_req) begin
      state_d = IDLE;
      cnt_d   = '0;
      rr_d    = 1'b0;
    end
  end

  // Ownership state, RAM command registers and read-return pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      ram_w_en_q  <= 1'b0;
      ram_r_en_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_a_q      <= 1'b0;
      rd_b_q      <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ram_r_en_q <= a_gnt_c | (b_gnt_c & ~b_we);
      ram_w_en_q <= b_gnt_c & b_we;
      if (a_gnt_c) begin
        ram_addr_q <= a_addr;
      end else if (b_gnt_c) begin
        ram_addr_q <= b_addr;
        if (b_we) ram_wdata_q <= b_wdata;
      end
      rd_a_q     <= a_gnt_c;
      rd_b_q     <= b_gnt_c & ~b_we;
      a_rvalid_q <= rd_a_q;
      b_rvalid_q <= rd_b_q;
      if (a_rvalid_q) a_hold_q <= ram_rdata;
      if (b_rvalid_q) b_hold_q <= ram_rdata;
      busy_q     <= (state_d != IDLE) | a_gnt_c | (b_gnt_c & ~b_we) | rd_a_q | rd_b_q;
    end
  end

  assign a_gnt     = a_gnt_c;
  assign b_gnt     = b_gnt_c;
  assign ram_w_en  = ram_w_en_q;
  assign ram_r_en  = ram_r_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  // RAM output is already registered; pass it through in the valid cycle, else hold
  assign a_rdata   = a_rvalid_q ? ram_rdata : a_hold_q;
  assign b_rdata   = b_rvalid_q ? ram_rdata : b_hold_q;
  assign busy      = busy_q;

`ifdef CONV_RAM_ARB_STATS_EN
  logic [SW-1:0] stat_a_q, stat_b_q;
  logic [FW-1:0] stat_f_q;

  // Saturating beat and forced-exit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
      stat_f_q <= '0;
    end else begin
      if (a_gnt_c && stat_a_q != '1) stat_a_q <= stat_a_q + SW'(1);
      if (b_gnt_c && stat_b_q != '1) stat_b_q <= stat_b_q + SW'(1);
      if (force_c && stat_f_q != '1) stat_f_q <= stat_f_q + FW'(1);
    end
  end

  assign stat_a_beats = stat_a_q;
  assign stat_b_beats = stat_b_q;
  assign stat_force   = stat_f_q;
`endif

endmodule

// File: tb/tb_conv_ram_arbiter.sv
// tb_conv_ram_arbiter: directed scenarios plus a random run for conv_ram_arbiter,
// with a behavioural 4096x8 registered-read RAM and a per-port read scoreboard.
module tb_conv_ram_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXB = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_w_en, ram_r_en, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef CONV_RAM_ARB_STATS_EN
  logic [15:0]   stat_a_beats, stat_b_beats;
  logic [7:0]    stat_force;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;
  ent_t qa[$];
  ent_t qb[$];

  conv_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_lock    (a_lock),
    .a_addr    (a_addr),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_lock    (b_lock),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_w_en  (ram_w_en),
    .ram_r_en  (ram_r_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
`ifdef CONV_RAM_ARB_STATS_EN
    ,
    .stat_a_beats (stat_a_beats),
    .stat_b_beats (stat_b_beats),
    .stat_force   (stat_force)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 16) return 8'h5A;
    return 8'(i * 7 + 3);
  endfunction

  // Behavioural RAM: write and registered read on posedge
  logic [DW-1:0] mem [0:4095];
  logic          ram_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      ram_done <= 1'b1;
    end else begin
      if (ram_w_en) mem[ram_addr] <= ram_wdata;
      if (ram_r_en) ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard and protocol invariants, sampled on the falling edge
  logic [DW-1:0] shadow [0:4095];
  logic          shadow_done = 1'b0;
  always @(negedge clk) begin : mon
    ent_t e;
    if (!shadow_done) begin
      for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
      shadow_done = 1'b1;
    end
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++; $display("FAIL one_gnt: a_gnt=%b b_gnt=%b at cycle %0d", a_gnt, b_gnt, cyc);
      end
      checks++;
      if ((a_gnt && !a_req) || (b_gnt && !b_req)) begin
        errors++; $display("FAIL gnt_wo_req: a %b/%b b %b/%b at cycle %0d", a_gnt, a_req, b_gnt, b_req, cyc);
      end
      checks++;
      if (ram_w_en && ram_r_en) begin
        errors++; $display("FAIL wen_ren: both enables high at cycle %0d", cyc);
      end
      if (a_rvalid) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL a_unexp_rvalid: a_rvalid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          e = qa.pop_front();
          if (a_rdata !== e.data || cyc != e.cyc + 2) begin
            errors++; $display("FAIL a_sb: data %h cycle %0d, expected %h cycle %0d", a_rdata, cyc, e.data, e.cyc + 2);
          end
        end
      end
      if (b_rvalid) begin
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL b_unexp_rvalid: b_rvalid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          e = qb.pop_front();
          if (b_rdata !== e.data || cyc != e.cyc + 2) begin
            errors++; $display("FAIL b_sb: data %h cycle %0d, expected %h cycle %0d", b_rdata, cyc, e.data, e.cyc + 2);
          end
        end
      end
      if (a_gnt) qa.push_back('{data: shadow[a_addr], cyc: cyc});
      if (b_gnt) begin
        if (b_we) shadow[b_addr] = b_wdata;
        else      qb.push_back('{data: shadow[b_addr], cyc: cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 0; a_lock = 0; a_addr = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_w_en, ram_r_en, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: flags=%b expected 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_w_en, ram_r_en, busy});
    end
    checks++;
    if ({a_rdata, b_rdata, ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: %h %h %h %h expected 0", a_rdata, b_rdata, ram_addr, ram_wdata);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_single_read();
    a_req = 1; a_addr = 12'h010;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt: a_gnt=%b b_gnt=%b expected 1/0", a_gnt, b_gnt);
    end
    tick();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (ram_r_en !== 1'b1 || ram_w_en !== 1'b0 || ram_addr !== 12'h010 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_cmd: r_en=%b w_en=%b addr=%h rvalid=%b expected 1/0/010/0", ram_r_en, ram_w_en, ram_addr, a_rvalid);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: busy=%b expected 1", busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h5A || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_rdata: a_rvalid=%b a_rdata=%h b_rvalid=%b expected 1/5a/0", a_rvalid, a_rdata, b_rvalid);
    end
    checks++;
    if (ram_r_en !== 1'b0 || ram_addr !== 12'h010) begin
      errors++; $display("FAIL idle_hold: r_en=%b addr=%h expected 0/010", ram_r_en, ram_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 8'h5A) begin
      errors++; $display("FAIL rdata_hold: a_rvalid=%b a_rdata=%h expected 0/5a", a_rvalid, a_rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    apply_reset();
    a_req = 1; a_addr = 12'h030;
    b_req = 1; b_we = 1; b_addr = 12'h020; b_wdata = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1)) begin
        errors++; $display("FAIL alt_gnt[%0d]: a_gnt=%b b_gnt=%b expected %b/%b", k, a_gnt, b_gnt, k % 2 == 0, k % 2 == 1);
      end
      tick();
    end
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_burst_lock();
    apply_reset();
    a_req = 1; a_lock = 1; a_addr = 12'h100;
    b_req = 1; b_we = 0; b_addr = 12'h200;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== (k < MAXB) || b_gnt !== (k == MAXB)) begin
        errors++; $display("FAIL burst_gnt[%0d]: a_gnt=%b b_gnt=%b expected %b/%b", k, a_gnt, b_gnt, k < MAXB, k == MAXB);
      end
      tick();
      if (a_gnt) a_addr = a_addr + 12'd1;
    end
    clear_inputs();
    tick(); tick(); tick();
`ifdef CONV_RAM_ARB_STATS_EN
    checks++;
    if (stat_force !== 8'd1 || stat_a_beats !== 16'd9 || stat_b_beats !== 16'd1) begin
      errors++; $display("FAIL burst_stats: force=%0d a=%0d b=%0d expected 1/9/1", stat_force, stat_a_beats, stat_b_beats);
    end
`endif
  endtask

  task automatic test_write_then_read();
    b_req = 1; b_we = 1; b_addr = 12'hFFF; b_wdata = 8'hC3;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_gnt: b_gnt=%b expected 1", b_gnt);
    end
    tick();
    b_req = 0; b_we = 0;
    a_req = 1; a_addr = 12'hFFF;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || ram_w_en !== 1'b1 || ram_wdata !== 8'hC3) begin
      errors++; $display("FAIL raw_a_gnt: a_gnt=%b w_en=%b wdata=%h expected 1/1/c3", a_gnt, ram_w_en, ram_wdata);
    end
    tick();
    a_req = 0;
    b_req = 1; b_addr = 12'h000;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1) begin
      errors++; $display("FAIL b_rd_gnt: b_gnt=%b expected 1", b_gnt);
    end
    tick();
    b_req = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'hC3 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL raw_rdata: a_rvalid=%b a_rdata=%h b_rvalid=%b expected 1/c3/0", a_rvalid, a_rdata, b_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== init_val(0) || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL b_rdata: b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1/%h/0", b_rvalid, b_rdata, a_rvalid, init_val(0));
    end
    tick();
  endtask

  task automatic test_reset_midread();
    apply_reset();
    a_req = 1; a_addr = 12'h010;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: a_gnt=%b expected 1", a_gnt);
    end
    tick();
    a_req = 0;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_w_en, ram_r_en, busy} !== 7'b0 || ram_addr !== '0) begin
      errors++; $display("FAIL mid_reset: flags=%b addr=%h expected 0/000", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_w_en, ram_r_en, busy}, ram_addr);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_discard: a_rvalid=%b expected 0", a_rvalid);
    end
    tick();
    a_req = 1; a_addr = 12'h040;
    b_req = 1; b_we = 0; b_addr = 12'h050;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL post_reset_tie: a_gnt=%b b_gnt=%b a_rvalid=%b expected 1/0/0", a_gnt, b_gnt, a_rvalid);
    end
    tick();
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_random(input int ncyc);
    int m_state = 0;
    bit m_rr    = 0;
    int m_cnt   = 0;
    int m_force = 0;
    int m_a     = 0;
    int m_b     = 0;
    bit pa = 0, pb = 0;
    bit ea, eb, lim;
    apply_reset();
    for (int k = 0; k < ncyc; k++) begin
      if (pa) a_req = ($urandom_range(0, 7) != 0);
      else begin
        a_req  = ($urandom_range(0, 9) < 6);
        a_addr = 12'($urandom_range(0, 15));
      end
      a_lock = 1'($urandom_range(0, 1));
      if (pb) b_req = ($urandom_range(0, 7) != 0);
      else begin
        b_req   = ($urandom_range(0, 9) < 6);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = 12'($urandom_range(0, 15));
        b_wdata = 8'($urandom);
      end
      b_lock = 1'($urandom_range(0, 1));
      @(negedge clk);
      ea = 0; eb = 0;
      case (m_state)
        0: if (a_req && b_req) begin ea = !m_rr; eb = m_rr; end
           else begin ea = a_req; eb = b_req; end
        1: ea = a_req;
        default: eb = b_req;
      endcase
      checks++;
      if (a_gnt !== ea || b_gnt !== eb) begin
        errors++; $display("FAIL rand_gnt[%0d]: a_gnt=%b b_gnt=%b expected %b/%b", k, a_gnt, b_gnt, ea, eb);
      end
      pa = a_req && !a_gnt;
      pb = b_req && !b_gnt;
      lim = (m_cnt + 1 >= MAXB);
      if (ea) begin
        m_a++; m_rr = 1;
        if (a_lock && !(lim && b_req)) begin m_state = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : m_cnt; end
        else begin if (a_lock) m_force++; m_state = 0; m_cnt = 0; end
      end else if (eb) begin
        m_b++; m_rr = 0;
        if (b_lock && !(lim && a_req)) begin m_state = 2; m_cnt = (m_cnt < 255) ? m_cnt + 1 : m_cnt; end
        else begin if (b_lock) m_force++; m_state = 0; m_cnt = 0; end
      end else if (m_state == 1 && !a_req) begin
        m_state = 0; m_cnt = 0; m_rr = 1;
      end else if (m_state == 2 && !b_req) begin
        m_state = 0; m_cnt = 0; m_rr = 0;
      end
      tick();
    end
    clear_inputs();
    tick(); tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL rand_drain: outstanding a=%0d b=%0d expected 0/0", qa.size(), qb.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rand_busy: busy=%b expected 0", busy);
    end
`ifdef CONV_RAM_ARB_STATS_EN
    checks++;
    if (stat_a_beats !== 16'(m_a) || stat_b_beats !== 16'(m_b) || stat_force !== 8'(m_force > 255 ? 255 : m_force)) begin
      errors++; $display("FAIL rand_stats: a=%0d b=%0d f=%0d expected %0d/%0d/%0d", stat_a_beats, stat_b_beats, stat_force, m_a, m_b, m_force);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_burst_lock();
    test_write_then_read();
    test_reset_midread();
    test_random(4000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
